digit_scan_ctrl: RTL

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/digit_scan_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/digit_scan_ctrl.sv
// Multiplexed 6-digit display scanner: walks the enabled digits in ascending order,
// blanking every output before each digit slot to suppress ghosting.
module digit_scan_ctrl #(
    parameter int SHOW_CYCLES  = 14,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [5:0] i_digit_mask,
    input  logic [3:0] i_data,
    output logic [2:0] o_sel,
    output logic [5:0] o_digit_en,
    output logic [3:0] o_data,
    output logic       o_frame_start
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);
    localparam logic [7:0] SHOW_LOAD  = 8'(SHOW_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] first_idx;
    logic [2:0] next_idx;
    logic [5:0] sel_onehot;

    function automatic logic [2:0] lowest_index(input logic [5:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Falls back to the lowest set bit when nothing lies above cur, which is the wrap case.
    function automatic logic [2:0] next_index(input logic [5:0] mask, input logic [2:0] cur);
        logic [2:0] idx;
        logic       found;
        idx   = lowest_index(mask);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!found && mask[i] && (3'(i) > cur)) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign first_idx  = lowest_index(i_digit_mask);
    assign next_idx   = next_index(i_digit_mask, o_sel);
    assign sel_onehot = 6'b000001 << o_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            o_sel         <= 3'd0;
            o_digit_en    <= 6'd0;
            o_data        <= 4'hF;
            o_frame_start <= 1'b0;
        end else begin
            o_data        <= i_data;
            o_frame_start <= 1'b0;
            o_digit_en    <= 6'd0;
            if (!i_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_digit_mask != 6'd0) begin
                            o_sel         <= first_idx;
                            cnt           <= BLANK_LOAD;
                            o_frame_start <= 1'b1;
                            state         <= BLANK;
                        end
                    end
                    BLANK: begin
                        if (i_digit_mask == 6'd0) begin
                            state <= IDLE;
                        end else if (cnt == 8'd0) begin
                            cnt        <= SHOW_LOAD;
                            o_digit_en <= sel_onehot & i_digit_mask;
                            state      <= SHOW;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    SHOW: begin
                        if (i_digit_mask == 6'd0) begin
                            state <= IDLE;
                        end else if (cnt == 8'd0) begin
                            o_sel         <= next_idx;
                            cnt           <= BLANK_LOAD;
                            o_frame_start <= (next_idx <= o_sel);
                            state         <= BLANK;
                        end else begin
                            cnt        <= cnt - 8'd1;
                            o_digit_en <= sel_onehot & i_digit_mask;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
